fuzz_alu_responder: RTL
=======================

FUZZ_ALU_RESPONDER -- requirements
Module: fuzz_alu_responder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, operand/result width; EXEC_LATENCY, default 2, cycles from request accept to response valid (>=1); RSP_TIMEOUT, default 16, cycles a response may stall before being dropped.
REQ-002 SHALL have ports as follows; one clock, reset synchronous and active-high:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  fuzz_en  in  1  request isolation of the ALU from the SoC for fuzzing
  soc_a, soc_b  in  DATA_WIDTH  SoC operands
  soc_op  in  4  SoC opcode
  soc_result  out  DATA_WIDTH  registered SoC result
  soc_carry  out  1  registered SoC carry
  soc_busy  out  1  high while isolated; SoC path frozen
  req_valid  in  1  fuzzer vector valid
  req_ready  out  1  responder can accept a vector
  req_a, req_b  in  DATA_WIDTH  fuzz operands
  req_op  in  4  fuzz opcode
  rsp_valid  out  1  response valid
  rsp_ready  in  1  fuzzer accepts response
  rsp_result  out  DATA_WIDTH  fuzz result
  rsp_carry, rsp_overflow, rsp_illegal  out  1 each  response flags
  timeout_flag  out  1  sticky: a response was dropped
  vec_count  out  16  completed responses, saturating

Function
REQ-003 SHALL implement states IDLE, ISOLATE, READY, EXEC, RESPOND, RELEASE.
REQ-004 IDLE: soc_result/soc_carry SHALL register the ALU output of soc_a/soc_b/soc_op every cycle; fuzz_en=1 -> ISOLATE.
REQ-005 ISOLATE SHALL last exactly one cycle, clear vec_count and timeout_flag, then -> READY.
REQ-006 soc_busy SHALL be 1 in every state except IDLE; soc_result/soc_carry SHALL hold their last value while soc_busy=1.
REQ-007 req_ready SHALL equal (state==READY && fuzz_en); a vector is accepted when req_valid && req_ready, operands captured, -> EXEC.
REQ-008 READY with fuzz_en=0 SHALL -> RELEASE, accepting no vector that cycle.
REQ-009 EXEC SHALL last exactly EXEC_LATENCY cycles, then -> RESPOND with rsp_valid=1 on the first RESPOND cycle.
REQ-010 rsp_* SHALL remain stable while rsp_valid && !rsp_ready; completion on rsp_valid && rsp_ready increments vec_count (saturating at 16'hFFFF).
REQ-011 After completion: fuzz_en=1 -> READY, fuzz_en=0 -> RELEASE; fuzz_en falling during EXEC/RESPOND SHALL NOT abort the vector in flight.
REQ-012 If rsp_valid stalls RSP_TIMEOUT consecutive cycles the response SHALL be dropped (rsp_valid=0), timeout_flag set, vec_count unchanged, next state chosen as in REQ-011.
REQ-013 RELEASE SHALL last one cycle then -> IDLE; soc_result resumes updating the cycle after entering IDLE.
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount b[4:0]), 8 SLT signed, 9 SLTU (result 0/1); 10-15 illegal: result 0, carry 0, overflow 0, illegal 1.
REQ-015 Carry SHALL be bit DATA_WIDTH of a+b (ADD) or of a+~b+1 (SUB, 1 means no borrow); 0 for other ops.
REQ-016 Overflow SHALL be two's-complement signed overflow for ADD and SUB; 0 for other ops.

Reset
REQ-017 rst=1 SHALL force state IDLE; req_ready, rsp_valid, soc_busy, timeout_flag 0; soc_result, soc_carry, rsp_result, rsp flags, vec_count 0; internal counters 0.
REQ-018 rst asserted mid-EXEC or mid-RESPOND SHALL discard the in-flight vector with no response emitted.

Structure
REQ-019 A shared package fuzz_pkg SHALL hold the opcode enum, the state enum and DATA_WIDTH/opcode-width constants.
REQ-020 The ALU datapath SHALL be one combinational sub-module fuzz_alu_core, instantiated once for the SoC path and once for the fuzz path.

Verification
REQ-021 Reset, fuzz_en=0, soc_a=5, soc_b=3, soc_op=0 -> soc_result=8 one cycle later, soc_busy=0.
REQ-022 fuzz_en=1; vector a=32'hFFFFFFFF, b=1, op=0 -> rsp_valid EXEC_LATENCY cycles after accept, result 0, carry 1, overflow 0, vec_count=1.
REQ-023 Vector a=32'h7FFFFFFF, b=1, op=0, then a=0, b=1, op=1 -> result 32'h80000000 overflow 1; then 32'hFFFFFFFF carry 0 overflow 0.
REQ-024 op=4'hC -> result 0, illegal 1; op=7, a=32'h80000000, b=4 -> 32'hF8000000.
REQ-025 rsp_ready held 0 -> after 16 cycles rsp_valid drops, timeout_flag=1, vec_count unchanged; fuzz_en dropped during EXEC -> response still delivered, then RELEASE, IDLE, soc_busy=0.
REQ-026 rst pulsed during EXEC -> no rsp_valid, all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/fuzz_pkg.sv
// Shared constants, opcode and state encodings for the fuzzing ALU responder.
package fuzz_pkg;

    localparam int unsigned FUZZ_DATA_WIDTH = 32;
    localparam int unsigned OP_WIDTH        = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISOLATE,
        S_READY,
        S_EXEC,
        S_RESPOND,
        S_RELEASE
    } state_e;

endpackage

// File: rtl/fuzz_alu_core.sv
// Purely combinational ALU shared by the SoC path and the fuzz path.
module fuzz_alu_core
    import fuzz_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FUZZ_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  overflow,
    output logic                  illegal
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic [4:0]          shamt;

    // Subtraction as a + ~b + 1 so the top bit reads as "no borrow".
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign shamt = b[4:0];

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum[MSB:0];
                carry    = sum[DATA_WIDTH];
                overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result   = diff[MSB:0];
                carry    = diff[DATA_WIDTH];
                overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fuzz_alu_responder.sv
// Isolates the ALU from the SoC and serves fuzzer vectors through a
// valid/ready request/response handshake with a bounded response stall.
module fuzz_alu_responder
    import fuzz_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = FUZZ_DATA_WIDTH,
    parameter int unsigned EXEC_LATENCY = 2,
    parameter int unsigned RSP_TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fuzz_en,
    input  logic [DATA_WIDTH-1:0] soc_a,
    input  logic [DATA_WIDTH-1:0] soc_b,
    input  logic [OP_WIDTH-1:0]   soc_op,
    output logic [DATA_WIDTH-1:0] soc_result,
    output logic                  soc_carry,
    output logic                  soc_busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [OP_WIDTH-1:0]   req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_overflow,
    output logic                  rsp_illegal,
    output logic                  timeout_flag,
    output logic [15:0]           vec_count
);

    localparam logic [15:0] EXEC_LAST  = 16'(EXEC_LATENCY - 1);
    localparam logic [15:0] STALL_LAST = 16'(RSP_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic [OP_WIDTH-1:0]   fop_q, fop_d;
    logic [15:0]           exec_cnt_q, exec_cnt_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
    logic [15:0]           vec_cnt_q, vec_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] soc_res_q, soc_res_d;
    logic                  soc_carry_q, soc_carry_d;
    logic [DATA_WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic                  rsp_c_q, rsp_c_d, rsp_o_q, rsp_o_d, rsp_i_q, rsp_i_d;

    logic [DATA_WIDTH-1:0] soc_alu_res, f_alu_res;
    logic                  soc_alu_c, soc_alu_o, soc_alu_i;
    logic                  f_alu_c, f_alu_o, f_alu_i;

    fuzz_alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_soc_alu (
        .a(soc_a), .b(soc_b), .op(soc_op),
        .result(soc_alu_res), .carry(soc_alu_c), .overflow(soc_alu_o), .illegal(soc_alu_i)
    );

    fuzz_alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_fuzz_alu (
        .a(fa_q), .b(fb_q), .op(fop_q),
        .result(f_alu_res), .carry(f_alu_c), .overflow(f_alu_o), .illegal(f_alu_i)
    );

    always_comb begin
        state_d     = state_q;
        fa_d        = fa_q;
        fb_d        = fb_q;
        fop_d       = fop_q;
        exec_cnt_d  = exec_cnt_q;
        stall_cnt_d = stall_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        timeout_d   = timeout_q;
        soc_res_d   = soc_res_q;
        soc_carry_d = soc_carry_q;
        rsp_res_d   = rsp_res_q;
        rsp_c_d     = rsp_c_q;
        rsp_o_d     = rsp_o_q;
        rsp_i_d     = rsp_i_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                soc_res_d   = soc_alu_res;
                soc_carry_d = soc_alu_c;
                if (fuzz_en) state_d = S_ISOLATE;
            end
            S_ISOLATE: begin
                vec_cnt_d = '0;
                timeout_d = 1'b0;
                state_d   = S_READY;
            end
            S_READY: begin
                if (!fuzz_en) begin
                    state_d = S_RELEASE;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        fa_d       = req_a;
                        fb_d       = req_b;
                        fop_d      = req_op;
                        exec_cnt_d = '0;
                        state_d    = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (exec_cnt_q == EXEC_LAST) begin
                    rsp_res_d   = f_alu_res;
                    rsp_c_d     = f_alu_c;
                    rsp_o_d     = f_alu_o;
                    rsp_i_d     = f_alu_i;
                    stall_cnt_d = '0;
                    state_d     = S_RESPOND;
                end else begin
                    exec_cnt_d = exec_cnt_q + 16'd1;
                end
            end
            S_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + 16'd1;
                    state_d = fuzz_en ? S_READY : S_RELEASE;
                end else if (stall_cnt_q == STALL_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = fuzz_en ? S_READY : S_RELEASE;
                end else begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fa_q        <= '0;
            fb_q        <= '0;
            fop_q       <= '0;
            exec_cnt_q  <= '0;
            stall_cnt_q <= '0;
            vec_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            soc_res_q   <= '0;
            soc_carry_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_c_q     <= 1'b0;
            rsp_o_q     <= 1'b0;
            rsp_i_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            fop_q       <= fop_d;
            exec_cnt_q  <= exec_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            timeout_q   <= timeout_d;
            soc_res_q   <= soc_res_d;
            soc_carry_q <= soc_carry_d;
            rsp_res_q   <= rsp_res_d;
            rsp_c_q     <= rsp_c_d;
            rsp_o_q     <= rsp_o_d;
            rsp_i_q     <= rsp_i_d;
        end
    end

    assign soc_busy     = (state_q != S_IDLE);
    assign soc_result   = soc_res_q;
    assign soc_carry    = soc_carry_q;
    assign rsp_result   = rsp_res_q;
    assign rsp_carry    = rsp_c_q;
    assign rsp_overflow = rsp_o_q;
    assign rsp_illegal  = rsp_i_q;
    assign timeout_flag = timeout_q;
    assign vec_count    = vec_cnt_q;

endmodule
